weight_buf_writer: RTL

Write-side controller for the weight buffer whose read side is stepped by the weight read counter. It accepts a stream of weight words over a valid/ready handshake and writes exactly OUTPUT_NUM words into the weight memory at addresses 0..OUTPUT_NUM-1. It then holds the buffer full until the read side releases it. It sits between the off-chip/DMA weight feed and the weight memory write port.

---
 rtl/weight_buf_writer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/weight_buf_writer.sv
`default_nettype none
// ============================================================================
// Module      : weight_buf_writer
// Description : Write-side controller for the weight buffer. Accepts
//               OUTPUT_NUM weight words over valid/ready, writes them to
//               addresses 0..OUTPUT_NUM-1, then holds the buffer full until
//               the read side releases it.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_buf_writer #(
  parameter int DATA_W     = 16,
  parameter int MEM_ADDR   = 4,
  parameter int OUTPUT_NUM = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                release_i,
  input  logic                in_valid_i,
  input  logic [DATA_W-1:0]   in_data_i,
  output logic                in_ready_o,
  output logic                wr_en_o,
  output logic [MEM_ADDR-1:0] wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic                load_done_o,
  output logic                buf_full_o,
  output logic                busy_o
);

  localparam logic [MEM_ADDR-1:0] C_LAST_ADDR = MEM_ADDR'(OUTPUT_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [MEM_ADDR-1:0] wr_cnt_q, wr_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [MEM_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                load_done_q, load_done_d;
  logic                w_accept;
  logic                w_last;

  // Handshake flags are decoded from the state register only, so in_ready
  // drops the cycle after the final accept and no extra word slips in.
  always_comb begin
    w_accept = in_valid_i && (state_q == LOAD);
    w_last   = (wr_cnt_q == C_LAST_ADDR);
  end

  // Next-state, write counter and registered memory-port values.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    load_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
        end
      end
      LOAD: begin
        if (w_accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_cnt_q;
          wr_data_d = in_data_i;
          if (w_last) begin
            wr_cnt_d    = '0;
            state_d     = FULL;
            load_done_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        // A release with a simultaneous start refills back-to-back.
        if (release_i) begin
          if (start_i) begin
            state_d  = LOAD;
            wr_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        wr_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      load_done_q <= load_done_d;
    end
  end

  // Output mapping.
  always_comb begin
    in_ready_o  = (state_q == LOAD);
    busy_o      = (state_q == LOAD);
    buf_full_o  = (state_q == FULL);
    wr_en_o     = wr_en_q;
    wr_addr_o   = wr_addr_q;
    wr_data_o   = wr_data_q;
    load_done_o = load_done_q;
  end

endmodule
`default_nettype wire
